// File: rtl/maze_wall_gen.sv
// Maze wall generator: fills wall bits from a 32-bit LFSR, then carves one guaranteed path
// from the bottom-left cell to the top-right cell. Define MAZE_BORDER_EN to pin the outer walls high.
module maze_wall_gen #(
    parameter int          H_N  = 5,
    parameter int          V_N  = 5,
    parameter logic [31:0] SEED = 32'd30504031
) (
    input  logic                 sec_clock,
    input  logic                 reset,
    input  logic                 i_regen,
    output logic [H_N*V_N-1:0]   o_wall_h,
    output logic [H_N*V_N-1:0]   o_wall_v,
    output logic                 o_ready,
    output logic [7:0]           o_level
);

    // state | meaning
    // GEN   | random fill of wall bits, one cell per cycle
    // CARVE | staircase walk from (0,V_N-1) to (H_N-1,0), clearing one wall per step
    // DONE  | maze stable, o_ready high until regen
    typedef enum logic [1:0] {
        GEN   = 2'd0,
        CARVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int                 N         = H_N * V_N;
    localparam int                 IDX_W     = $clog2(N) + 1;
    localparam logic [31:0]        SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [IDX_W-1:0]   ONE       = IDX_W'(1);
    localparam logic [IDX_W-1:0]   C_LAST    = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0]   I_LAST    = IDX_W'(H_N - 1);
    localparam logic [IDX_W-1:0]   J_START   = IDX_W'(V_N - 1);
    localparam logic [IDX_W-1:0]   V_W       = IDX_W'(V_N);
    localparam logic [IDX_W-1:0]   STEP_LOAD = IDX_W'(H_N + V_N - 3);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_lfsr;
    logic               w_lfsr_fb;
    logic [IDX_W-1:0]   r_c;
    logic [IDX_W-1:0]   w_c_nxt;
    logic [IDX_W-1:0]   r_i;
    logic [IDX_W-1:0]   w_i_nxt;
    logic [IDX_W-1:0]   r_j;
    logic [IDX_W-1:0]   w_j_nxt;
    logic [IDX_W-1:0]   r_step;
    logic [IDX_W-1:0]   w_step_nxt;
    logic [N-1:0]       r_wall_h;
    logic [N-1:0]       w_wall_h_nxt;
    logic [N-1:0]       r_wall_v;
    logic [N-1:0]       w_wall_v_nxt;
    logic               r_ready;
    logic               w_ready_nxt;
    logic [7:0]         r_level;
    logic [7:0]         w_level_nxt;
    logic [IDX_W-1:0]   w_cell;
    logic [IDX_W-1:0]   w_up_idx;
    logic               w_move_up;

    assign w_lfsr_fb = r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0];
    assign w_cell    = (r_i * V_W) + r_j;
    // An up move opens the bottom edge of the cell above the current one.
    assign w_up_idx  = w_cell - ONE;

    always_ff @(posedge sec_clock) begin
        if (!reset) begin
            r_state  <= GEN;
            r_lfsr   <= SEED_EFF;
            r_c      <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_step   <= '0;
            r_wall_h <= '1;
            r_wall_v <= '1;
            r_ready  <= 1'b0;
            r_level  <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_lfsr   <= {r_lfsr[30:0], w_lfsr_fb};
            r_c      <= w_c_nxt;
            r_i      <= w_i_nxt;
            r_j      <= w_j_nxt;
            r_step   <= w_step_nxt;
            r_wall_h <= w_wall_h_nxt;
            r_wall_v <= w_wall_v_nxt;
            r_ready  <= w_ready_nxt;
            r_level  <= w_level_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_c_nxt      = r_c;
        w_i_nxt      = r_i;
        w_j_nxt      = r_j;
        w_step_nxt   = r_step;
        w_wall_h_nxt = r_wall_h;
        w_wall_v_nxt = r_wall_v;
        w_ready_nxt  = r_ready;
        w_level_nxt  = r_level;
        w_move_up    = 1'b0;

        case (r_state)
            GEN: begin
                if (i_regen) begin
                    w_c_nxt = '0;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        if (IDX_W'(k) == r_c) begin
                            w_wall_h_nxt[k] = r_lfsr[0];
                            w_wall_v_nxt[k] = r_lfsr[1];
                        end
                    end
                    if (r_c == C_LAST) begin
                        w_state_nxt = CARVE;
                        w_i_nxt     = '0;
                        w_j_nxt     = J_START;
                        w_step_nxt  = STEP_LOAD;
                    end else begin
                        w_c_nxt = r_c + ONE;
                    end
                end
            end

            CARVE: begin
                if (i_regen) begin
                    w_state_nxt = GEN;
                    w_c_nxt     = '0;
                end else begin
                    // Right-column and top-row positions have only one legal direction.
                    if (r_i == I_LAST) begin
                        w_move_up = 1'b1;
                    end else if (r_j == '0) begin
                        w_move_up = 1'b0;
                    end else begin
                        w_move_up = ~r_lfsr[0];
                    end

                    for (int k = 0; k < N; k++) begin
                        if (w_move_up && (IDX_W'(k) == w_up_idx)) begin
                            w_wall_h_nxt[k] = 1'b0;
                        end
                        if (!w_move_up && (IDX_W'(k) == w_cell)) begin
                            w_wall_v_nxt[k] = 1'b0;
                        end
                    end

                    if (w_move_up) begin
                        w_j_nxt = r_j - ONE;
                    end else begin
                        w_i_nxt = r_i + ONE;
                    end

                    if (r_step == '0) begin
                        w_state_nxt = DONE;
                        w_ready_nxt = 1'b1;
                        if (r_level != 8'hFF) begin
                            w_level_nxt = r_level + 8'd1;
                        end
                    end else begin
                        w_step_nxt = r_step - ONE;
                    end
                end
            end

            DONE: begin
                if (i_regen) begin
                    w_state_nxt = GEN;
                    w_ready_nxt = 1'b0;
                    w_c_nxt     = '0;
                end
            end

            default: begin
                w_state_nxt = GEN;
                w_c_nxt     = '0;
            end
        endcase
    end

`ifdef MAZE_BORDER_EN
    function automatic logic [N-1:0] border_h_mask();
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < H_N; i++) begin
            m[i*V_N + V_N - 1] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [N-1:0] border_v_mask();
        logic [N-1:0] m;
        m = '0;
        for (int j = 0; j < V_N; j++) begin
            m[(H_N-1)*V_N + j] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [N-1:0] BORDER_H = border_h_mask();
    localparam logic [N-1:0] BORDER_V = border_v_mask();

    assign o_wall_h = r_wall_h | BORDER_H;
    assign o_wall_v = r_wall_v | BORDER_V;
`else
    assign o_wall_h = r_wall_h;
    assign o_wall_v = r_wall_v;
`endif

    assign o_ready = r_ready;
    assign o_level = r_level;

endmodule

// File: tb/tb_maze_wall_gen.sv
// Bench for maze_wall_gen: table-driven reset/regen/abort sequences on a 5x5 instance,
// a long regen run for solvability and level saturation, and an 8x3 SEED=0 instance.
module tb_maze_wall_gen;

    localparam logic [31:0] SEED_A = 32'd30504031;

    logic        sec_clock = 1'b0;
    logic        reset;
    logic        regen;
    logic [24:0] wall_h;
    logic [24:0] wall_v;
    logic        ready;
    logic [7:0]  level;

    logic        reset_b;
    logic        regen_b;
    logic [23:0] wall_h_b;
    logic [23:0] wall_v_b;
    logic        ready_b;
    logic [7:0]  level_b;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_lfsr;
    logic [31:0] m_start;

    always #5 sec_clock = ~sec_clock;

    maze_wall_gen #(.H_N(5), .V_N(5), .SEED(SEED_A)) dut (
        .sec_clock (sec_clock),
        .reset     (reset),
        .i_regen   (regen),
        .o_wall_h  (wall_h),
        .o_wall_v  (wall_v),
        .o_ready   (ready),
        .o_level   (level)
    );

    maze_wall_gen #(.H_N(8), .V_N(3), .SEED(32'd0)) dut_b (
        .sec_clock (sec_clock),
        .reset     (reset_b),
        .i_regen   (regen_b),
        .o_wall_h  (wall_h_b),
        .o_wall_v  (wall_v_b),
        .o_ready   (ready_b),
        .o_level   (level_b)
    );

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    // Reference maze from the LFSR value present at the first GEN edge.
    task automatic build_maze(input logic [31:0] start, input int h, input int v,
                              output logic [63:0] wh, output logic [63:0] wv);
        logic [31:0] l;
        int i;
        int j;
        l  = start;
        wh = '0;
        wv = '0;
        for (int k = 0; k < h*v; k++) begin
            wh[k] = l[0];
            wv[k] = l[1];
            l = lfsr_next(l);
        end
        i = 0;
        j = v - 1;
        for (int s = 0; s < h + v - 2; s++) begin
            if (i == h - 1 || (j != 0 && l[0] == 1'b0)) begin
                wh[i*v + j - 1] = 1'b0;
                j = j - 1;
            end else begin
                wv[i*v + j] = 1'b0;
                i = i + 1;
            end
            l = lfsr_next(l);
        end
`ifdef MAZE_BORDER_EN
        for (int ii = 0; ii < h; ii++) wh[ii*v + v - 1] = 1'b1;
        for (int jj = 0; jj < v; jj++) wv[(h-1)*v + jj] = 1'b1;
`endif
    endtask

    function automatic bit solvable(input logic [63:0] wh, input logic [63:0] wv,
                                    input int h, input int v);
        bit reach [16][16];
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) reach[a][b] = 1'b0;
        reach[0][v-1] = 1'b1;
        for (int p = 0; p < h*v; p++) begin
            for (int i = 0; i < h; i++) begin
                for (int j = 0; j < v; j++) begin
                    if (reach[i][j]) begin
                        if (j < v-1 && !wh[i*v + j])       reach[i][j+1] = 1'b1;
                        if (j > 0   && !wh[i*v + j - 1])   reach[i][j-1] = 1'b1;
                        if (i < h-1 && !wv[i*v + j])       reach[i+1][j] = 1'b1;
                        if (i > 0   && !wv[(i-1)*v + j])   reach[i-1][j] = 1'b1;
                    end
                end
            end
        end
        return reach[h-1][0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One edge on the 5x5 instance; the model tracks the register LFSR and the GEN start value.
    task automatic step(input logic rst, input logic rg);
        reset = rst;
        regen = rg;
        @(posedge sec_clock);
        if (!rst) begin
            m_lfsr  = SEED_A;
            m_start = SEED_A;
        end else begin
            m_lfsr = lfsr_next(m_lfsr);
            if (rg) m_start = m_lfsr;
        end
        #1;
    endtask

    task automatic check_model(input string name);
        logic [63:0] eh;
        logic [63:0] ev;
        build_maze(m_start, 5, 5, eh, ev);
        chk({name, " wall_h"}, {39'd0, wall_h}, eh);
        chk({name, " wall_v"}, {39'd0, wall_v}, ev);
        chk({name, " solvable"}, {63'd0, solvable({39'd0, wall_h}, {39'd0, wall_v}, 5, 5)}, 64'd1);
    endtask

    typedef struct {
        logic       rst;
        logic       rg;
        int         n;
        logic       exp_ready;
        logic [7:0] exp_level;
        int         wall_chk;   // 0 none, 1 reference maze, 2 all ones
    } vec_t;

    vec_t tbl [23];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  border;
        bit          border_bad;
        bit          border_zero;
        int          cnt;
        int          exp_lvl;
        logic [63:0] eh;
        logic [63:0] ev;

        reset   = 1'b0;
        regen   = 1'b0;
        reset_b = 1'b0;
        regen_b = 1'b0;
        m_lfsr  = SEED_A;
        m_start = SEED_A;

        tbl[0]  = '{1'b0, 1'b0,  3, 1'b0, 8'd0, 2};
        tbl[1]  = '{1'b1, 1'b0, 32, 1'b0, 8'd0, 0};
        tbl[2]  = '{1'b1, 1'b0,  1, 1'b1, 8'd1, 1};
        tbl[3]  = '{1'b1, 1'b0,  5, 1'b1, 8'd1, 1};
        tbl[4]  = '{1'b1, 1'b1,  1, 1'b0, 8'd1, 0};
        tbl[5]  = '{1'b1, 1'b0, 32, 1'b0, 8'd1, 0};
        tbl[6]  = '{1'b1, 1'b0,  1, 1'b1, 8'd2, 1};
        tbl[7]  = '{1'b1, 1'b1,  1, 1'b0, 8'd2, 0};
        tbl[8]  = '{1'b1, 1'b0,  9, 1'b0, 8'd2, 0};
        tbl[9]  = '{1'b1, 1'b1,  1, 1'b0, 8'd2, 0};
        tbl[10] = '{1'b1, 1'b0, 32, 1'b0, 8'd2, 0};
        tbl[11] = '{1'b1, 1'b0,  1, 1'b1, 8'd3, 1};
        tbl[12] = '{1'b1, 1'b0, 30, 1'b1, 8'd3, 1};
        tbl[13] = '{1'b1, 1'b1,  1, 1'b0, 8'd3, 0};
        tbl[14] = '{1'b1, 1'b0, 28, 1'b0, 8'd3, 0};
        tbl[15] = '{1'b0, 1'b1,  1, 1'b0, 8'd0, 2};
        tbl[16] = '{1'b1, 1'b0, 32, 1'b0, 8'd0, 0};
        tbl[17] = '{1'b1, 1'b0,  1, 1'b1, 8'd1, 1};
        tbl[18] = '{1'b1, 1'b1,  1, 1'b0, 8'd1, 0};
        tbl[19] = '{1'b1, 1'b0, 27, 1'b0, 8'd1, 0};
        tbl[20] = '{1'b1, 1'b1,  1, 1'b0, 8'd1, 0};
        tbl[21] = '{1'b1, 1'b0, 32, 1'b0, 8'd1, 0};
        tbl[22] = '{1'b1, 1'b0,  1, 1'b1, 8'd2, 1};

        for (int r = 0; r < 23; r++) begin
            for (int e = 0; e < tbl[r].n; e++) begin
                step(tbl[r].rst, tbl[r].rg);
                chk($sformatf("vec%0d.%0d ready", r, e), {63'd0, ready}, {63'd0, tbl[r].exp_ready});
                chk($sformatf("vec%0d.%0d level", r, e), {56'd0, level}, {56'd0, tbl[r].exp_level});
                if (tbl[r].wall_chk == 1) begin
                    check_model($sformatf("vec%0d.%0d", r, e));
                end else if (tbl[r].wall_chk == 2) begin
                    chk($sformatf("vec%0d.%0d reset wall_h", r, e), {39'd0, wall_h}, {39'd0, 25'h1FF_FFFF});
                    chk($sformatf("vec%0d.%0d reset wall_v", r, e), {39'd0, wall_v}, {39'd0, 25'h1FF_FFFF});
                end
            end
        end

        // Long regen run: latency, solvability and level saturation.
        border_bad  = 1'b0;
        border_zero = 1'b0;
        for (int k = 3; k <= 258; k++) begin
            step(1'b1, 1'b1);
            cnt = 0;
            do begin
                step(1'b1, 1'b0);
                cnt++;
                border = {wall_h[4], wall_h[9], wall_h[14], wall_h[19], wall_h[24], wall_v[24:20]};
                if (border != 10'h3FF) begin
                    border_bad = 1'b1;
                    if (k < 23) border_zero = 1'b1;
                end
            end while (!ready && cnt < 40);
            exp_lvl = (k > 255) ? 255 : k;
            chk($sformatf("regen%0d latency", k), 64'(cnt), 64'd33);
            chk($sformatf("regen%0d level", k), {56'd0, level}, 64'(exp_lvl));
            check_model($sformatf("regen%0d", k));
        end
`ifdef MAZE_BORDER_EN
        chk("border pinned", {63'd0, border_bad}, 64'd0);
`else
        chk("border random", {63'd0, border_zero}, 64'd1);
`endif

        // 8x3 instance with SEED=0: LFSR starts at 1.
        @(posedge sec_clock);
        #1;
        chk("b reset wall_h", {40'd0, wall_h_b}, {40'd0, 24'hFF_FFFF});
        chk("b reset ready", {63'd0, ready_b}, 64'd0);
        reset_b = 1'b1;
        cnt = 0;
        do begin
            @(posedge sec_clock);
            #1;
            cnt++;
        end while (!ready_b && cnt < 60);
        chk("b latency", 64'(cnt), 64'd33);
        chk("b level", {56'd0, level_b}, 64'd1);
        build_maze(32'd1, 8, 3, eh, ev);
        chk("b wall_h", {40'd0, wall_h_b}, eh);
        chk("b wall_v", {40'd0, wall_v_b}, ev);
        chk("b solvable", {63'd0, solvable({40'd0, wall_h_b}, {40'd0, wall_v_b}, 8, 3)}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maze_wall_gen.md
MAZE_WALL_GEN -- requirements
Module: maze_wall_gen

Interface
REQ-001 Parameter H_N, default 5: number of maze columns; legal range 2..16.
REQ-002 Parameter V_N, default 5: number of maze rows; legal range 2..16.
REQ-003 Parameter SEED, default 32'd30504031: LFSR load value; a value of 0 SHALL be replaced by 32'd1.
REQ-004 sec_clock  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 regen  input  1  single-cycle request for a new maze.
REQ-007 wall_h  output  H_N*V_N  1 = bottom edge of cell (i,j) is a wall; bit index i*V_N+j, where i is the column and j the row (row 0 at top).
REQ-008 wall_v  output  H_N*V_N  1 = right edge of cell (i,j) is a wall; same bit indexing as wall_h.
REQ-009 ready  output  1  walls are stable and contain a guaranteed path.
REQ-010 level  output  8  count of completed mazes.

Function
REQ-011 The block SHALL contain a 32-bit Fibonacci LFSR, polynomial x^32+x^22+x^2+x+1, shifting on every edge while reset=1.
REQ-012 The FSM SHALL have three states: GEN, CARVE and DONE.
REQ-013 GEN SHALL run for H_N*V_N cycles, using a counter c from 0 to H_N*V_N-1.
- Each cycle: wall_h[c] <= lfsr[0] and wall_v[c] <= lfsr[1].
- After c = H_N*V_N-1, the FSM SHALL go to CARVE with position (i,j) = (0,V_N-1).
REQ-014 CARVE SHALL run for exactly H_N+V_N-2 cycles, with one step per cycle.
- If i = H_N-1: move up.
- Else if j = 0: move right.
- Otherwise: lfsr[0]=1 moves right, lfsr[0]=0 moves up.
REQ-015 An up move SHALL clear wall_h[i*V_N+j-1] and set j <= j-1.
REQ-016 A right move SHALL clear wall_v[i*V_N+j] and set i <= i+1.
REQ-017 On the final carve step, position becomes (H_N-1,0), the FSM SHALL enter DONE, and ready <= 1 on the same edge.
REQ-018 On entering DONE, level SHALL increment, saturating at 255.
REQ-019 Latency from the first edge with reset=1 to ready=1 SHALL be H_N*V_N+H_N+V_N-2 edges (33 for 5x5).
REQ-020 In DONE, walls SHALL hold and ready SHALL stay 1 until regen.
REQ-021 regen=1 in DONE SHALL clear ready on the next edge, set c to 0 and enter GEN; the LFSR is not reloaded.
REQ-022 regen=1 in GEN or CARVE SHALL abort the build and restart GEN with c=0; level SHALL NOT change.
REQ-023 While ready=0, consumers SHALL ignore wall_h and wall_v; their contents are partial.
REQ-024 Index arithmetic SHALL be sized to $clog2(H_N*V_N)+1 bits; no wrap-around is permitted.

Reset
REQ-025 When reset=0 at an edge:
- wall_h and wall_v SHALL be all ones.
- ready SHALL be 0 and level SHALL be 0.
- LFSR SHALL be SEED (or 1 if SEED=0), c SHALL be 0, and the state SHALL be GEN.
REQ-026 Reset SHALL take priority over regen and over any in-progress GEN or CARVE, including mid-carve.
REQ-027 Generation SHALL start automatically on the first edge with reset=1.

Configuration
REQ-028 Macro MAZE_BORDER_EN selects border handling.
- When defined: wall_h bits with j=V_N-1 and wall_v bits with i=H_N-1 SHALL be forced to 1 in every state; GEN writes to those bits are discarded.
- When undefined: those bits SHALL be random like all other bits.
- In both configurations, the carve path never clears a border bit.

Verification
REQ-029 Default parameters, hold reset=0 for 3 edges, then release:
- ready=0 during edges 1..32; ready=1 after edge 33; level=1.
REQ-030 After ready=1:
- Flood-fill from cell (0,4) through non-wall edges SHALL reach cell (4,0).
- Repeat for 100 regen cycles; every maze SHALL be solvable and level SHALL be 100 (saturating at 255 after 255 regens).
REQ-031 Pulse regen at edge 10 of GEN:
- level is unchanged; ready is first seen after 33 edges counted from the regen edge.
REQ-032 Assert reset=0 during CARVE step 4:
- wall_h and wall_v all ones, ready=0, level=0 on the next edge; regeneration then repeats the identical maze (same SEED).
REQ-033 SEED=0 and H_N=8, V_N=3:
- LFSR is loaded with 1; ready after 33 edges (24+9); the path ends at (7,0).
REQ-034 With MAZE_BORDER_EN defined:
- wall_h bits 4,9,14,19,24 and wall_v bits 20..24 read 1 throughout; undefined-macro build shows at least one 0 among them over 20 mazes.
